// File: rtl/tt_harness_pkg.sv
// Shared types and constants for the Tiny Tapeout I/O self-test harness.
// Holds the FSM state enum, mode encodings and vector field slots.
package tt_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CORE_RST,
    ST_REPLAY,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic MODE_PASS     = 1'b0;
  localparam logic MODE_SELFTEST = 1'b1;

  // Field slots inside a vector word; bit offset is slot * W.
  // Word layout: {stim_ui, stim_uio, exp_uo, mask_uo}
  localparam int F_MASK = 0;
  localparam int F_EXP  = 1;
  localparam int F_UIO  = 2;
  localparam int F_UI   = 3;

endpackage

// File: rtl/tt_harness_vec_ram.sv
// Vector table: DEPTH x 4W register file.
// One synchronous write port, one asynchronous read port, no reset.
module tt_harness_vec_ram
  import tt_harness_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [4*W-1:0]  wdata,
  input  logic [AW-1:0]   raddr,
  output logic [4*W-1:0]  rdata
);

  logic [4*W-1:0] mem_q [DEPTH];

  // Table contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tt_io_selftest_harness.sv
// Pad-to-core harness: PASS straight-through or SELFTEST vector replay.
// Optional capture RAM with rd_addr/rd_data when TT_HARNESS_TRACE_EN is defined.
module tt_io_selftest_harness
  import tt_harness_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int DEPTH   = 16,
  parameter  int LAT     = 1,
  parameter  int RST_CYC = 4,
  parameter  int CNT_W   = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             start,
  input  logic [W-1:0]     pad_ui_in,
  input  logic [W-1:0]     pad_uio_in,
  input  logic             pad_rst_n,
  output logic [W-1:0]     pad_uo_out,
  output logic [W-1:0]     pad_uio_out,
  output logic [W-1:0]     pad_uio_oe,
  output logic [W-1:0]     core_ui_in,
  output logic [W-1:0]     core_uio_in,
  output logic             core_rst_n,
  input  logic [W-1:0]     core_uo_out,
  input  logic [W-1:0]     core_uio_out,
  input  logic [W-1:0]     core_uio_oe,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [4*W-1:0]   wr_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [AW-1:0]    first_err
`ifdef TT_HARNESS_TRACE_EN
  ,
  input  logic [AW-1:0]    rd_addr,
  output logic [W-1:0]     rd_data
`endif
);

  localparam int CMAX = (RST_CYC > LAT) ? RST_CYC : LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int EW   = W - 3;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [AW-1:0]    ferr_q, ferr_d;

  logic             pv_q   [LAT];
  logic [W-1:0]     pexp_q [LAT];
  logic [W-1:0]     pmsk_q [LAT];
  logic [AW-1:0]    pidx_q [LAT];

  logic [4*W-1:0]   vec;
  logic             accept;
  logic             replay;
  logic             mism;
  logic             pass_mode;
  logic             pass_w;
  logic [W-1:0]     stim_ui;
  logic [W-1:0]     stim_uio;
  logic [EW-1:0]    err_pad;

  tt_harness_vec_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_vec_ram (
    .clk   (clk),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q),
    .rdata (vec)
  );

  assign busy   = (state_q == ST_CORE_RST) ||
                  (state_q == ST_REPLAY)   ||
                  (state_q == ST_DRAIN);
  assign accept = start && (mode == MODE_SELFTEST) &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign replay = (state_q == ST_REPLAY);

  assign mism = pv_q[LAT-1] &&
                (|((core_uo_out ^ pexp_q[LAT-1]) & pmsk_q[LAT-1]));

  // Next state and the shared reset/drain counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CORE_RST;
          cnt_d   = '0;
        end
      end
      ST_CORE_RST: begin
        if (cnt_q == CW'(RST_CYC - 1)) begin
          state_d = ST_REPLAY;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REPLAY: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(LAT - 1)) state_d = ST_DONE;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE: begin
        if (accept) begin
          state_d = ST_CORE_RST;
          cnt_d   = '0;
        end else if (mode == MODE_PASS) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result status: cleared on an accepted start, updated by the checker.
  always_comb begin
    err_d  = err_q;
    ferr_d = ferr_q;
    done_d = done_q;
    if (accept) begin
      err_d  = '0;
      ferr_d = '0;
      done_d = 1'b0;
    end else begin
      if (mism) begin
        if (err_q == '0) ferr_d = pidx_q[LAT-1];
        if (err_q != '1) err_d  = err_q + CNT_W'(1);
      end
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) done_d = 1'b1;
    end
  end

  // FSM, counters and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  // Expected/mask/index pipeline aligning each vector with core output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        pv_q[k]   <= 1'b0;
        pexp_q[k] <= '0;
        pmsk_q[k] <= '0;
        pidx_q[k] <= '0;
      end
    end else begin
      pv_q[0]   <= replay;
      pexp_q[0] <= vec[F_EXP*W +: W];
      pmsk_q[0] <= vec[F_MASK*W +: W];
      pidx_q[0] <= idx_q;
      for (int k = 1; k < LAT; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pexp_q[k] <= pexp_q[k-1];
        pmsk_q[k] <= pmsk_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
      end
    end
  end

  assign pass_w    = done_q && (err_q == '0);
  assign pass_mode = (state_q == ST_IDLE) && (mode == MODE_PASS) && !rst;
  assign stim_ui   = replay ? vec[F_UI*W +: W]  : '0;
  assign stim_uio  = replay ? vec[F_UIO*W +: W] : '0;
  assign err_pad   = EW'(err_q);

  // Pin muxing: straight-through in PASS, vector drive and status otherwise.
  always_comb begin
    core_ui_in  = stim_ui;
    core_uio_in = '0;
    core_rst_n  = (state_q == ST_REPLAY) ||
                  (state_q == ST_DRAIN)  ||
                  (state_q == ST_DONE);
    pad_uo_out  = {busy, done_q, pass_w, err_pad};
    pad_uio_out = '0;
    pad_uio_oe  = '0;
    if (state_q != ST_IDLE) begin
      core_uio_in = (core_uio_out & core_uio_oe) |
                    (stim_uio & ~core_uio_oe);
    end
    if (pass_mode) begin
      core_ui_in  = pad_ui_in;
      core_uio_in = pad_uio_in;
      core_rst_n  = pad_rst_n;
      pad_uo_out  = core_uo_out;
      pad_uio_out = core_uio_out;
      pad_uio_oe  = core_uio_oe;
    end
  end

  assign done      = done_q;
  assign pass      = pass_w;
  assign err_count = err_q;
  assign first_err = ferr_q;

`ifdef TT_HARNESS_TRACE_EN
  logic [W-1:0] trc_q [DEPTH];
  logic [W-1:0] rd_q;

  // Capture core output at every compare slot.
  always_ff @(posedge clk) begin
    if (pv_q[LAT-1]) trc_q[pidx_q[LAT-1]] <= core_uo_out;
  end

  // Registered one-cycle read of the capture RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= trc_q[rd_addr];
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_tt_io_selftest_harness.sv
// Scoreboard bench for tt_io_selftest_harness with an echoing core model.
// A second instance with CNT_W=2 shares stimulus to observe saturation.
module tb_tt_io_selftest_harness;

  localparam int W       = 8;
  localparam int DEPTH   = 16;
  localparam int LAT     = 1;
  localparam int RST_CYC = 4;
  localparam int AW      = 4;
  localparam logic [W-1:0] UIO_OUT = 8'h5A;
  localparam logic [W-1:0] UIO_OE  = 8'hF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           mode = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   pad_ui_in = 8'h11;
  logic [W-1:0]   pad_uio_in = 8'h22;
  logic           pad_rst_n = 1'b1;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [4*W-1:0] wr_data = '0;
  logic [W-1:0]   core_uo_out;
  logic [W-1:0]   core_uio_out;
  logic [W-1:0]   core_uio_oe;
  logic [W-1:0]   echo_q = '0;

  logic [W-1:0]   pad_uo_out, pad_uio_out, pad_uio_oe;
  logic [W-1:0]   core_ui_in, core_uio_in;
  logic           core_rst_n, busy, done, pass;
  logic [7:0]     err_count;
  logic [AW-1:0]  first_err;

  logic [W-1:0]   s_uo, s_uio, s_oe, s_ui_in, s_uio_in;
  logic           s_rst_n, s_busy, s_done, s_pass;
  logic [1:0]     s_err;
  logic [AW-1:0]  s_ferr;

`ifdef TT_HARNESS_TRACE_EN
  logic [AW-1:0]  rd_addr = '0;
  logic [W-1:0]   rd_data, s_rd_data;
`endif

  assign core_uo_out  = echo_q;
  assign core_uio_out = UIO_OUT;
  assign core_uio_oe  = UIO_OE;

  // Core model: echoes ui_in onto uo_out one cycle later.
  always_ff @(posedge clk) echo_q <= core_ui_in;

  tt_io_selftest_harness #(.W(W), .DEPTH(DEPTH), .LAT(LAT),
    .RST_CYC(RST_CYC), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start),
    .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
    .pad_rst_n(pad_rst_n), .pad_uo_out(pad_uo_out),
    .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe),
    .core_ui_in(core_ui_in), .core_uio_in(core_uio_in),
    .core_rst_n(core_rst_n), .core_uo_out(core_uo_out),
    .core_uio_out(core_uio_out), .core_uio_oe(core_uio_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err(first_err)
`ifdef TT_HARNESS_TRACE_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  tt_io_selftest_harness #(.W(W), .DEPTH(DEPTH), .LAT(LAT),
    .RST_CYC(RST_CYC), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .mode(mode), .start(start),
    .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
    .pad_rst_n(pad_rst_n), .pad_uo_out(s_uo),
    .pad_uio_out(s_uio), .pad_uio_oe(s_oe),
    .core_ui_in(s_ui_in), .core_uio_in(s_uio_in),
    .core_rst_n(s_rst_n), .core_uo_out(core_uo_out),
    .core_uio_out(core_uio_out), .core_uio_oe(core_uio_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .first_err(s_ferr)
`ifdef TT_HARNESS_TRACE_EN
    , .rd_addr(rd_addr), .rd_data(s_rd_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference table and expected run outcomes.
  logic [W-1:0] m_ui [DEPTH];
  logic [W-1:0] m_uio[DEPTH];
  logic [W-1:0] m_exp[DEPTH];
  logic [W-1:0] m_msk[DEPTH];

  typedef struct {
    int cyc;
    int err;
    int ferr;
    bit pass;
    int serr;
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t model();
    exp_t e;
    int n = 0;
    int f = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((m_ui[i] ^ m_exp[i]) & m_msk[i]) != 0) begin
        if (n == 0) f = i;
        n++;
      end
    end
    e.cyc  = RST_CYC + DEPTH + LAT;
    e.err  = (n > 255) ? 255 : n;
    e.serr = (n > 3) ? 3 : n;
    e.ferr = f;
    e.pass = (n == 0);
    return e;
  endfunction

  // Monitor: on each rising done, pop and compare one run outcome.
  int  bcnt = 0;
  bit  pd = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt = 0;
      pd   = 1'b0;
    end else begin
      if (busy) bcnt++;
      if (done && !pd) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("busy_cycles", bcnt, e.cyc);
          chk("err_count", err_count, e.err);
          chk("first_err", first_err, e.ferr);
          chk("pass", pass, e.pass);
          chk("sat_err", s_err, e.serr);
          chk("sat_done", s_done, 1);
          chk("status_pins", pad_uo_out,
              {2'b01, e.pass, 5'(e.err)});
        end
        bcnt = 0;
      end
      pd = done;
    end
  end

  // Write the model table; the final write carries the start pulse.
  task automatic load_and_start();
    sb_q.push_back(model());
    for (int i = 0; i < DEPTH; i++) begin
      mode    = 1'b1;
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = {m_ui[i], m_uio[i], m_exp[i], m_msk[i]};
      start   = (i == DEPTH - 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b0;
    chk("core_rst_hold", core_rst_n, 0);
    repeat (RST_CYC) @(negedge clk);
  endtask

  task automatic run(input bit disturb);
    int k;
    load_and_start();
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("core_ui[%0d]", i), core_ui_in, m_ui[i]);
      chk($sformatf("core_uio[%0d]", i), core_uio_in,
          (UIO_OUT & UIO_OE) | (m_uio[i] & ~UIO_OE));
      if (disturb && i == 3) begin
        wr_en   = 1'b1;
        wr_addr = AW'(10);
        wr_data = {~m_ui[10], m_uio[10], ~m_exp[10], 8'hFF};
        start   = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic fill_clean();
    for (int i = 0; i < DEPTH; i++) begin
      m_ui[i]  = W'($urandom);
      m_uio[i] = W'($urandom);
      m_exp[i] = m_ui[i];
      m_msk[i] = 8'hFF;
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {pad_uo_out, pad_uio_out, pad_uio_oe, core_ui_in, core_uio_in,
         core_rst_n, busy, done, pass, err_count, first_err}, 0);
    rst = 1'b0;
    pad_ui_in = 8'hA5;
    #1;
    chk("pass_ui", core_ui_in, 8'hA5);
    chk("pass_uio", core_uio_in, 8'h22);
    chk("pass_rst_n", core_rst_n, 1);
    chk("pass_oe", pad_uio_oe, UIO_OE);
    chk("pass_uio_out", pad_uio_out, UIO_OUT);
    pad_ui_in = 8'h3C;
    @(negedge clk);
    chk("pass_uo", pad_uo_out, 8'h3C);
    mode = 1'b1;
    #1;
    chk("st_idle_oe", pad_uio_oe, 0);
    chk("st_idle_uo", pad_uo_out, 0);
    @(negedge clk);

    fill_clean();
    run(1'b0);
`ifdef TT_HARNESS_TRACE_EN
    rd_addr = AW'(4);
    @(negedge clk);
    chk("trace_rd", rd_data, m_ui[4]);
`endif

    m_exp[5] = m_exp[5] ^ W'($urandom_range(1, 255));
    m_exp[9] = m_exp[9] ^ W'($urandom_range(1, 255));
    run(1'b0);
    m_msk[5] = '0;
    m_msk[9] = '0;
    run(1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      m_exp[i] = ~m_ui[i];
      m_msk[i] = 8'hFF;
    end
    run(1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_ui[i]  = W'($urandom);
        m_uio[i] = W'($urandom);
        m_exp[i] = m_ui[i] ^
                   (($urandom_range(0, 3) == 0) ? W'($urandom) : W'(0));
        m_msk[i] = W'($urandom);
      end
      run(1'b0);
    end

    fill_clean();
    run(1'b1);

    load_and_start();
    repeat (7) @(negedge clk);
    void'(sb_q.pop_back());
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_core_rst_n", core_rst_n, 0);
    mode = 1'b0;
    pad_rst_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_follow", core_rst_n, 1);
    pad_rst_n = 1'b0;
    #1;
    chk("post_rst_follow0", core_rst_n, 0);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
